// File: rtl/srio_pkt_pkg.sv
// Shared SRIO logical-layer packet definitions: FTYPE/TTYPE codes, header field
// positions, doorbell info codes and the target FSM state encoding.
package srio_pkt_pkg;

    localparam logic [3:0] FTYPE_DOORB = 4'hA;
    localparam logic [3:0] FTYPE_NWR   = 4'h5;
    localparam logic [3:0] TTYPE_NWR   = 4'h4;

    localparam int HDR_TID_LSB   = 56;
    localparam int HDR_FTYPE_LSB = 52;
    localparam int HDR_TTYPE_LSB = 48;
    localparam int HDR_PRIO_LSB  = 45;
    localparam int HDR_SIZE_LSB  = 36;
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_INFO_LSB  = 16;

    localparam int ADDR_W = 34;

    localparam logic [15:0] DB_INFO_QUERY = 16'h0101;
    localparam logic [15:0] DB_INFO_READY = 16'h0100;
    localparam logic [15:0] DB_INFO_BUSY  = 16'h01FF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DB_RSP = 2'd1,
        ST_NWR    = 2'd2,
        ST_DROP   = 2'd3
    } tgt_state_e;

    // Payload beats of an NWRITE from the upper bits of the size-1 field.
    function automatic logic [5:0] nwr_exp_beats(input logic [4:0] size_m1_hi);
        return {1'b0, size_m1_hi} + 6'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/srio_axis_reg.sv
// One-deep registered AXI-Stream stage carrying data, keep, last and a byte
// address; ready is registered-output based so valid has no combinational path.
module srio_axis_reg
    import srio_pkt_pkg::*;
(
    input  logic              log_clk,
    input  logic              log_rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [63:0]       in_data_i,
    input  logic [7:0]        in_keep_i,
    input  logic              in_last_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [63:0]       out_data_o,
    output logic [7:0]        out_keep_o,
    output logic              out_last_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    logic              valid_q;
    logic [63:0]       data_q;
    logic [7:0]        keep_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;

    assign in_ready_o = out_ready_i | ~valid_q;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            if (in_ready_o) begin
                valid_q <= in_valid_i;
            end
            if (in_valid_i && in_ready_o) begin
                data_q <= in_data_i;
                keep_q <= in_keep_i;
                last_q <= in_last_i;
                addr_q <= in_addr_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;
    assign out_addr_o  = addr_q;

endmodule

// File: rtl/db_nwr_target.sv
// SRIO target endpoint: answers doorbell ready queries and strips NWRITE headers,
// streaming payload with a running address. Define DB_NWR_TARGET_STATS_EN for counters.
//
// state     | meaning
// ST_IDLE   | waiting for a header beat
// ST_DB_RSP | presenting the doorbell response until it is taken
// ST_NWR    | forwarding NWRITE payload beats to the user sink
// ST_DROP   | discarding the rest of an unsupported packet
module db_nwr_target
    import srio_pkt_pkg::*;
#(
    parameter logic [15:0] LOCAL_ID    = 16'h00F0,
    parameter logic [15:0] DB_REQ_INFO = DB_INFO_QUERY,
    parameter logic [15:0] INFO_READY  = DB_INFO_READY,
    parameter logic [15:0] INFO_BUSY   = DB_INFO_BUSY
) (
    input  logic              log_clk,
    input  logic              log_rst,
    input  logic              treq_tvalid_in,
    output logic              treq_tready_o,
    input  logic              treq_tlast_in,
    input  logic [63:0]       treq_tdata_in,
    input  logic [7:0]        treq_tkeep_in,
    input  logic [31:0]       treq_tuser_in,
    output logic              tresp_tvalid_o,
    input  logic              tresp_tready_in,
    output logic              tresp_tlast_o,
    output logic [63:0]       tresp_tdata_o,
    output logic [7:0]        tresp_tkeep_o,
    output logic [31:0]       tresp_tuser_o,
    input  logic              sink_busy_in,
    output logic              usr_tvalid_o,
    input  logic              usr_tready_in,
    output logic [63:0]       usr_tdata_o,
    output logic [7:0]        usr_tkeep_o,
    output logic              usr_tlast_o,
    output logic [ADDR_W-1:0] usr_addr_o,
    output logic              nwr_active_o,
    output logic              len_err_o
`ifdef DB_NWR_TARGET_STATS_EN
    ,
    output logic [15:0]       db_cnt_o,
    output logic [15:0]       nwr_pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    tgt_state_e        state_q, state_d;
    logic              rdy_en_q;
    logic [7:0]        tid_q;
    logic [1:0]        prio_q;
    logic [15:0]       src_q;
    logic [15:0]       info_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [5:0]        exp_q;
    logic [6:0]        cnt_q;
    logic              nwr_active_q, nwr_active_d;
    logic              len_err_q, len_err_d;

    logic [3:0]        hdr_ftype;
    logic [3:0]        hdr_ttype;
    logic              treq_fire, hdr_fire, nwr_beat;
    logic              is_db, is_nwr;
    logic [6:0]        beat_nx;
    logic              ureg_in_valid, ureg_in_ready;
    logic              last_handoff;
    logic [1:0]        prio_rsp;
    logic              unused_tuser;

    assign unused_tuser = ^treq_tuser_in[15:0];

    assign hdr_ftype = treq_tdata_in[HDR_FTYPE_LSB +: 4];
    assign hdr_ttype = treq_tdata_in[HDR_TTYPE_LSB +: 4];
    assign is_db     = (hdr_ftype == FTYPE_DOORB);
    assign is_nwr    = (hdr_ftype == FTYPE_NWR) && (hdr_ttype == TTYPE_NWR) && !treq_tlast_in;

    assign treq_fire = treq_tvalid_in & treq_tready_o;
    assign hdr_fire  = (state_q == ST_IDLE) & treq_fire;
    assign nwr_beat  = (state_q == ST_NWR) & treq_fire;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (is_db) begin
                        state_d = ST_DB_RSP;
                    end else if (is_nwr) begin
                        state_d = ST_NWR;
                    end else if (!treq_tlast_in) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DB_RSP: if (tresp_tready_in) state_d = ST_IDLE;
            ST_NWR:    if (treq_fire && treq_tlast_in) state_d = ST_IDLE;
            ST_DROP:   if (treq_fire && treq_tlast_in) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign prio_rsp = prio_q + 2'd1;

    // Headers are held off in IDLE while a payload beat is still stalled downstream.
    always_comb begin
        treq_tready_o  = 1'b0;
        tresp_tvalid_o = 1'b0;
        ureg_in_valid  = 1'b0;
        case (state_q)
            ST_IDLE:   treq_tready_o = rdy_en_q & ~(usr_tvalid_o & ~usr_tready_in);
            ST_DB_RSP: tresp_tvalid_o = 1'b1;
            ST_NWR: begin
                treq_tready_o = ureg_in_ready;
                ureg_in_valid = treq_tvalid_in;
            end
            ST_DROP:   treq_tready_o = 1'b1;
            default:   treq_tready_o = 1'b0;
        endcase
        tresp_tlast_o = tresp_tvalid_o;
        tresp_tkeep_o = 8'hFF;
        tresp_tdata_o = '0;
        tresp_tuser_o = '0;
        if (tresp_tvalid_o) begin
            tresp_tdata_o = {tid_q, FTYPE_DOORB, 4'h0, 1'b0, prio_rsp, 1'b0, 12'h0, info_q, 16'h0};
            tresp_tuser_o = {LOCAL_ID, src_q};
        end
    end

    assign beat_nx   = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
    assign len_err_d = nwr_beat &&
                       ((treq_tlast_in && (beat_nx != {1'b0, exp_q})) ||
                        (beat_nx == ({1'b0, exp_q} + 7'd1)));

    assign last_handoff = usr_tvalid_o & usr_tready_in & usr_tlast_o;

    always_comb begin
        nwr_active_d = nwr_active_q;
        if (hdr_fire && is_nwr) begin
            nwr_active_d = 1'b1;
        end else if (last_handoff) begin
            nwr_active_d = 1'b0;
        end
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            rdy_en_q     <= 1'b0;
            tid_q        <= '0;
            prio_q       <= '0;
            src_q        <= '0;
            info_q       <= '0;
            cur_addr_q   <= '0;
            exp_q        <= '0;
            cnt_q        <= '0;
            nwr_active_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            nwr_active_q <= nwr_active_d;
            len_err_q    <= len_err_d;
            if (hdr_fire && is_db) begin
                tid_q  <= treq_tdata_in[HDR_TID_LSB +: 8];
                prio_q <= treq_tdata_in[HDR_PRIO_LSB +: 2];
                src_q  <= treq_tuser_in[31:16];
                info_q <= (sink_busy_in || nwr_active_q ||
                           (treq_tdata_in[HDR_INFO_LSB +: 16] != DB_REQ_INFO)) ? INFO_BUSY : INFO_READY;
            end
            if (hdr_fire && is_nwr) begin
                cur_addr_q <= treq_tdata_in[HDR_ADDR_LSB +: ADDR_W];
                exp_q      <= nwr_exp_beats(treq_tdata_in[HDR_SIZE_LSB + 3 +: 5]);
                cnt_q      <= '0;
            end else if (nwr_beat) begin
                cur_addr_q <= cur_addr_q + ADDR_W'(8);
                cnt_q      <= beat_nx;
            end
        end
    end

    srio_axis_reg u_usr_reg (
        .log_clk     (log_clk),
        .log_rst     (log_rst),
        .in_valid_i  (ureg_in_valid),
        .in_ready_o  (ureg_in_ready),
        .in_data_i   (treq_tdata_in),
        .in_keep_i   (treq_tkeep_in),
        .in_last_i   (treq_tlast_in),
        .in_addr_i   (cur_addr_q),
        .out_valid_o (usr_tvalid_o),
        .out_ready_i (usr_tready_in),
        .out_data_o  (usr_tdata_o),
        .out_keep_o  (usr_tkeep_o),
        .out_last_o  (usr_tlast_o),
        .out_addr_o  (usr_addr_o)
    );

    assign nwr_active_o = nwr_active_q;
    assign len_err_o    = len_err_q;

`ifdef DB_NWR_TARGET_STATS_EN
    logic [15:0] db_cnt_q, nwr_cnt_q, drop_cnt_q;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            db_cnt_q   <= '0;
            nwr_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (hdr_fire) begin
            if (is_db) begin
                db_cnt_q <= sat_inc16(db_cnt_q);
            end else if (is_nwr) begin
                nwr_cnt_q <= sat_inc16(nwr_cnt_q);
            end else begin
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end
        end
    end

    assign db_cnt_o      = db_cnt_q;
    assign nwr_pkt_cnt_o = nwr_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_db_nwr_target.sv
// Scoreboard bench for db_nwr_target: expected usr beats and doorbell responses
// are queued as stimulus is driven and checked as the DUT hands them off.
module tb_db_nwr_target;

    logic        log_clk = 1'b0;
    logic        log_rst = 1'b1;
    logic        treq_tvalid_in = 1'b0;
    logic        treq_tready_o;
    logic        treq_tlast_in = 1'b0;
    logic [63:0] treq_tdata_in = '0;
    logic [7:0]  treq_tkeep_in = '0;
    logic [31:0] treq_tuser_in = '0;
    logic        tresp_tvalid_o;
    logic        tresp_tready_in = 1'b1;
    logic        tresp_tlast_o;
    logic [63:0] tresp_tdata_o;
    logic [7:0]  tresp_tkeep_o;
    logic [31:0] tresp_tuser_o;
    logic        sink_busy_in = 1'b0;
    logic        usr_tvalid_o;
    logic        usr_tready_in = 1'b1;
    logic [63:0] usr_tdata_o;
    logic [7:0]  usr_tkeep_o;
    logic        usr_tlast_o;
    logic [33:0] usr_addr_o;
    logic        nwr_active_o;
    logic        len_err_o;
`ifdef DB_NWR_TARGET_STATS_EN
    logic [15:0] db_cnt_o, nwr_pkt_cnt_o, drop_cnt_o;
`endif

    db_nwr_target dut (
        .log_clk         (log_clk),
        .log_rst         (log_rst),
        .treq_tvalid_in  (treq_tvalid_in),
        .treq_tready_o   (treq_tready_o),
        .treq_tlast_in   (treq_tlast_in),
        .treq_tdata_in   (treq_tdata_in),
        .treq_tkeep_in   (treq_tkeep_in),
        .treq_tuser_in   (treq_tuser_in),
        .tresp_tvalid_o  (tresp_tvalid_o),
        .tresp_tready_in (tresp_tready_in),
        .tresp_tlast_o   (tresp_tlast_o),
        .tresp_tdata_o   (tresp_tdata_o),
        .tresp_tkeep_o   (tresp_tkeep_o),
        .tresp_tuser_o   (tresp_tuser_o),
        .sink_busy_in    (sink_busy_in),
        .usr_tvalid_o    (usr_tvalid_o),
        .usr_tready_in   (usr_tready_in),
        .usr_tdata_o     (usr_tdata_o),
        .usr_tkeep_o     (usr_tkeep_o),
        .usr_tlast_o     (usr_tlast_o),
        .usr_addr_o      (usr_addr_o),
        .nwr_active_o    (nwr_active_o),
        .len_err_o       (len_err_o)
`ifdef DB_NWR_TARGET_STATS_EN
        ,
        .db_cnt_o        (db_cnt_o),
        .nwr_pkt_cnt_o   (nwr_pkt_cnt_o),
        .drop_cnt_o      (drop_cnt_o)
`endif
    );

    always #5 log_clk = ~log_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [33:0] addr;
    } usr_beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] user;
    } rsp_beat_t;

    usr_beat_t usr_q[$];
    rsp_beat_t rsp_q[$];
    usr_beat_t ue;
    rsp_beat_t re;

    int n_cmp = 0;
    int n_err = 0;
    int len_err_seen = 0;
    int len_err_exp  = 0;
    int rdy_mode = 0;  // 0: ready high, 1: toggle, 2: ready low

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rsp_word(input logic [7:0] tid, input logic [1:0] prio,
                                             input logic [15:0] info);
        logic [1:0] p;
        p = prio + 2'd1;
        return {tid, 4'hA, 4'h0, 1'b0, p, 1'b0, 12'h000, info, 16'h0000};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial forever begin
        @(posedge log_clk);
        #1;
        if (rdy_mode == 1)      usr_tready_in = ~usr_tready_in;
        else if (rdy_mode == 2) usr_tready_in = 1'b0;
        else                    usr_tready_in = 1'b1;
    end

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge log_clk) begin
        if (!log_rst) begin
            if (usr_tvalid_o && usr_tready_in) begin
                chk("usr_beat_expected", usr_q.size() != 0, 1'b1);
                if (usr_q.size() != 0) begin
                    ue = usr_q.pop_front();
                    chk("usr_data", usr_tdata_o, ue.data);
                    chk("usr_keep", usr_tkeep_o, ue.keep);
                    chk("usr_last", usr_tlast_o, ue.last);
                    chk("usr_addr", usr_addr_o, ue.addr);
                end
            end
            if (tresp_tvalid_o && tresp_tready_in) begin
                chk("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) begin
                    re = rsp_q.pop_front();
                    chk("rsp_data", tresp_tdata_o, re.data);
                    chk("rsp_user", tresp_tuser_o, re.user);
                    chk("rsp_last", tresp_tlast_o, 1'b1);
                    chk("rsp_keep", tresp_tkeep_o, 8'hFF);
                end
            end
            if (len_err_o) len_err_seen++;
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [31:0] u);
        int n = 0;
        treq_tvalid_in = 1'b1;
        treq_tdata_in  = d;
        treq_tkeep_in  = k;
        treq_tlast_in  = l;
        treq_tuser_in  = u;
        @(negedge log_clk);
        while (!treq_tready_o && n < 300) begin
            n++;
            @(negedge log_clk);
        end
        chk("treq_accept_in_time", n < 300, 1'b1);
        @(posedge log_clk);
        #1;
        treq_tvalid_in = 1'b0;
        treq_tlast_in  = 1'b0;
    endtask

    task automatic send_db(input logic [7:0] tid, input logic [1:0] prio, input logic [15:0] info,
                           input logic [15:0] src, input logic [15:0] exp_info);
        logic [63:0] h;
        rsp_beat_t r;
        h = '0;
        h[63:56] = tid;
        h[55:52] = 4'hA;
        h[46:45] = prio;
        h[31:16] = info;
        r.data = rsp_word(tid, prio, exp_info);
        r.user = {16'h00F0, src};
        rsp_q.push_back(r);
        send_beat(h, 8'hFF, 1'b1, {src, 16'h00F0});
    endtask

    task automatic send_nwr(input logic [33:0] addr, input logic [7:0] size_m1, input int nbeats);
        logic [63:0] h;
        logic [63:0] d;
        logic [7:0]  k;
        usr_beat_t   b;
        int          expb;
        h = '0;
        h[55:52] = 4'h5;
        h[51:48] = 4'h4;
        h[43:36] = size_m1;
        h[33:0]  = addr;
        expb = int'(size_m1 >> 3) + 1;
        if (nbeats > expb + 1)   len_err_exp += 2;
        else if (nbeats != expb) len_err_exp += 1;
        send_beat(h, 8'hFF, 1'b0, 32'h0022_00F0);
        chk("nwr_active_after_hdr", nwr_active_o, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            d = {$urandom, $urandom};
            k = (i == nbeats - 1) ? 8'h0F : 8'hFF;
            b.data = d;
            b.keep = k;
            b.last = (i == nbeats - 1);
            b.addr = addr + 34'(8 * i);
            usr_q.push_back(b);
            send_beat(d, k, i == nbeats - 1, 32'h0022_00F0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((usr_q.size() != 0 || rsp_q.size() != 0 || usr_tvalid_o || tresp_tvalid_o) && n < 500) begin
            @(posedge log_clk);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge log_clk);
            #1;
        end
        chk("drain_usr_q", usr_q.size(), 0);
        chk("drain_rsp_q", rsp_q.size(), 0);
    endtask

    initial begin
        logic [63:0] h;
        logic [63:0] hold_exp;

        repeat (2) @(posedge log_clk);
        @(negedge log_clk);
        chk("rst_treq_tready", treq_tready_o, 1'b0);
        chk("rst_tresp_tvalid", tresp_tvalid_o, 1'b0);
        chk("rst_tresp_tdata", tresp_tdata_o, 64'h0);
        chk("rst_tresp_tkeep", tresp_tkeep_o, 8'hFF);
        chk("rst_usr_tvalid", usr_tvalid_o, 1'b0);
        chk("rst_nwr_active", nwr_active_o, 1'b0);
        chk("rst_len_err", len_err_o, 1'b0);
        @(posedge log_clk);
        #1;
        log_rst = 1'b0;
        @(posedge log_clk);
        #1;

        // doorbell ready query, then busy by sink and by wrong info
        send_db(8'h00, 2'd1, 16'h0101, 16'h0011, 16'h0100);
        drain();
        sink_busy_in = 1'b1;
        send_db(8'h00, 2'd1, 16'h0101, 16'h0011, 16'h01FF);
        drain();
        sink_busy_in = 1'b0;
        send_db(8'h00, 2'd1, 16'h0202, 16'h0011, 16'h01FF);
        drain();

        // 32-beat NWRITE with toggling sink ready
        rdy_mode = 1;
        send_nwr(34'h0_0010_0000, 8'hFF, 32);
        drain();
        rdy_mode = 0;
        drain();
        chk("nwr_active_after_last", nwr_active_o, 1'b0);
        chk("len_err_ok_pkt", len_err_seen, len_err_exp);

        // short NWRITE: tlast on beat 6 of 8, then FSM must answer a doorbell
        send_nwr(34'h3_FFFF_FFF0, 8'h3F, 6);
        drain();
        chk("len_err_short_pkt", len_err_seen, len_err_exp);
        send_db(8'h33, 2'd2, 16'h0101, 16'h0044, 16'h0100);
        drain();

        // unsupported FTYPE 2 packet dropped, doorbell back-to-back
        h = '0;
        h[55:52] = 4'h2;
        send_beat(h, 8'hFF, 1'b0, 32'h0055_00F0);
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 32'h0055_00F0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 32'h0055_00F0);
        send_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b1, 32'h0055_00F0);
        send_db(8'h7E, 2'd0, 16'h0101, 16'h0066, 16'h0100);
        drain();
        chk("len_err_after_drop", len_err_seen, len_err_exp);

        // response backpressure: held stable, requests blocked
        tresp_tready_in = 1'b0;
        hold_exp = rsp_word(8'h5A, 2'd3, 16'h0100);
        send_db(8'h5A, 2'd3, 16'h0101, 16'h0077, 16'h0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge log_clk);
            chk("hold_tresp_tvalid", tresp_tvalid_o, 1'b1);
            chk("hold_tresp_tdata", tresp_tdata_o, hold_exp);
            chk("hold_treq_tready", treq_tready_o, 1'b0);
        end
        @(posedge log_clk);
        #1;
        tresp_tready_in = 1'b1;
        drain();

        // reset in the middle of an NWRITE with a stalled payload beat
        rdy_mode = 2;
        @(posedge log_clk);
        #1;
        h = '0;
        h[55:52] = 4'h5;
        h[51:48] = 4'h4;
        h[43:36] = 8'h1F;
        h[33:0]  = 34'h0_0000_4000;
        send_beat(h, 8'hFF, 1'b0, 32'h0022_00F0);
        send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 32'h0022_00F0);
        @(negedge log_clk);
        chk("mid_usr_tvalid", usr_tvalid_o, 1'b1);
        chk("mid_nwr_active", nwr_active_o, 1'b1);
        @(posedge log_clk);
        #1;
        log_rst = 1'b1;
        #1;
        chk("mrst_usr_tvalid", usr_tvalid_o, 1'b0);
        chk("mrst_usr_tdata", usr_tdata_o, 64'h0);
        chk("mrst_usr_addr", usr_addr_o, 34'h0);
        chk("mrst_usr_tlast", usr_tlast_o, 1'b0);
        chk("mrst_nwr_active", nwr_active_o, 1'b0);
        chk("mrst_treq_tready", treq_tready_o, 1'b0);
        chk("mrst_tresp_tvalid", tresp_tvalid_o, 1'b0);
        chk("mrst_tresp_tkeep", tresp_tkeep_o, 8'hFF);
        usr_q.delete();
        rdy_mode = 0;
        repeat (2) begin
            @(posedge log_clk);
            #1;
        end
        log_rst = 1'b0;
        @(posedge log_clk);
        #1;
        send_db(8'h01, 2'd1, 16'h0101, 16'h0099, 16'h0100);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
